// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-requester SDRAM port arbiter: display reads have priority, blitter writes are starvation-bounded
module sdram_arbiter #(
  parameter int ADDR_W        = 22,
  parameter int DATA_W        = 128,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              sdram_Wait,
  input  logic              sdram_ac,
  input  logic [DATA_W-1:0] sdram_rddata,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  output logic              sdram_wr,
  output logic [DATA_W-1:0] sdram_wrdata,
  output logic              owner
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_RD_STREAK);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t     state, state_next;
  logic [3:0] rd_streak;
  logic       grant_rd, grant_wr;

  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (!sdram_Wait) begin
          // Reads win unless the writer has already been passed over STREAK_MAX times.
          if (rd_req && wr_req) begin
            if (rd_streak == STREAK_MAX) grant_wr = 1'b1;
            else                         grant_rd = 1'b1;
          end else if (rd_req) begin
            grant_rd = 1'b1;
          end else if (wr_req) begin
            grant_wr = 1'b1;
          end
        end
        if (grant_rd) state_next = RD;
        if (grant_wr) state_next = WR;
      end
      RD:      if (sdram_ac) state_next = RESP;
      WR:      if (sdram_ac) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rd_streak    <= '0;
      sdram_addr   <= '0;
      sdram_wrdata <= '0;
      rd_data      <= '0;
      owner        <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_rd) begin
        sdram_addr <= rd_addr;
        owner      <= 1'b0;
        if (!wr_req)                      rd_streak <= '0;
        else if (rd_streak != STREAK_MAX) rd_streak <= rd_streak + 4'd1;
      end
      if (grant_wr) begin
        sdram_addr   <= wr_addr;
        sdram_wrdata <= wr_data;
        owner        <= 1'b1;
        rd_streak    <= '0;
      end
      if (state == RD && sdram_ac) rd_data <= sdram_rddata;
    end
  end

  assign sdram_rd = (state == RD);
  assign sdram_wr = (state == WR);
  assign rd_ack   = (state == RESP) && !owner;
  assign wr_ack   = (state == RESP) &&  owner;

endmodule
